net_tx_arbiter: RTL and testbench
=================================

# net_tx_arbiter

Packet-level round-robin arbiter with token-bucket rate limiting for the NIC transmit path. It merges N independent 64-bit flit streams (data/keep/last) into the single `net_out` stream. Packets are never interleaved. Egress is paced by the `rlimit_inc` / `rlimit_period` / `rlimit_size` configuration that the network endpoint supplies.

## Interface
- `N_IN`, 2: number of requesting transmit streams (2..8).
- `IDX_W`, `$clog2(N_IN)` (min 1): grant index width.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in N_IN: per-requester flit valid.
- `in_ready` out N_IN: per-requester flit accept.
- `in_data` in 64*N_IN: flit data, requester i at bits [64i+63:64i].
- `in_keep` in 8*N_IN: byte keep, requester i at [8i+7:8i].
- `in_last` in N_IN: last flit of packet.
- `out_valid` out 1: merged flit valid.
- `out_ready` in 1: downstream accept.
- `out_data` out 64: merged data.
- `out_keep` out 8: merged keep.
- `out_last` out 1: merged last.
- `rlimit_inc` in 8: tokens added per refill.
- `rlimit_period` in 8: refill occurs every `rlimit_period`+1 cycles.
- `rlimit_size` in 8: token bucket capacity (max burst in flits).
- `grant` out IDX_W: index of the currently owning requester.
- `busy` out 1: high while a packet is in progress.

## Operation
- **State machine**, two states: IDLE and BUSY.
  - IDLE: search `in_valid` starting at (`last_grant`+1) mod N_IN, wrapping. On the first set bit, register `grant` and go to BUSY. If no bit is set, stay in IDLE.
  - BUSY: the stream is owned by `grant`.
    - A handshake is `out_valid` && `out_ready`.
    - A handshake with `out_last`=1 sets `last_grant` to `grant` and returns the FSM to IDLE.
- **Datapath in BUSY**:
  - `out_valid` = `in_valid[grant]` && `tokens` != 0.
  - `in_ready[grant]` = `out_ready` && `tokens` != 0. All other `in_ready` bits are 0.
  - `out_data`, `out_keep` and `out_last` are muxed combinationally from `grant`.
- **Datapath in IDLE**: all `in_ready` bits are 0, `out_valid` is 0, and `out_data`/`out_keep`/`out_last` are 0.
- **Period counter** (8 bit):
  - Increments every cycle.
  - When it equals `rlimit_period`, it clears to 0 and a refill fires that cycle.
  - If `rlimit_period` is lowered below the current count, the counter keeps incrementing and wraps through 255, then 0.
- **Tokens** (9-bit internal):
  - next = min(`tokens` + (refill ? `rlimit_inc` : 0), `rlimit_size`) − (handshake ? 1 : 0).
  - The saturation is computed before the consume, so a simultaneous refill and consume is well defined.
  - A handshake only occurs when `tokens` != 0, so underflow cannot happen.
- **Live configuration changes**: the config inputs may change at any time. The new `rlimit_size` clamps the bucket at the next refill, or on the next cycle if `tokens` exceeds it.
- **Degenerate sizes**:
  - `rlimit_size`=0 blocks egress permanently.
  - With `rlimit_inc`=1 and `rlimit_period`=0, the bucket allows full rate.
- **Reset mid-packet**: FSM returns to IDLE and the tokens and counter clear. The partial packet is abandoned with no flush. Requesters are responsible for their own reset.

## Timing
- **Reset values**:
  - FSM=IDLE, `tokens`=0, period counter=0, `last_grant`=N_IN−1 (so requester 0 wins first), `grant`=0.
  - All outputs are 0: `busy`, `out_valid`, `in_ready`, `out_data`, `out_keep`, `out_last`.
- **Grant latency**: `in_valid` sampled in IDLE at cycle t gives `busy`=1 and a valid `grant` at t+1. The earliest output flit is at t+1.
- **Throughput**: in BUSY, input to output is zero latency (combinational pass-through). With enough tokens, 1 flit per cycle.
- **Packet gap**: exactly one IDLE bubble cycle between consecutive packets.
- **Stable grant**: `grant` holds from grant until the last flit's handshake, whatever other requesters do.
- **Handshake rules**:
  - `out_valid` never depends on `out_ready`.
  - Once asserted, `out_valid` stays asserted until handshake provided the requester holds `in_valid`. A refill cannot remove tokens, so this holds.
- **First refill**: tokens are 0 out of reset, so the first refill lands at cycle `rlimit_period`+1 after reset release.

## Test plan
- **Single requester, full rate.** inc=1, period=0, size=8. Requester 0 sends a 4-flit packet with `out_ready`=1.
  - Required: after the first refill, flits appear on 4 consecutive cycles.
  - Required: `out_last` on the 4th flit; `busy` drops the cycle after.
- **Round-robin fairness.** N_IN=3, all requesters continuously valid with 2-flit packets.
  - Required: grant order 0,1,2,0,1,2.
  - Required: no interleaving, and one bubble between packets.
- **Rate limiting.** inc=1, period=3, size=2. 10-flit packet, `out_ready`=1.
  - Required: after an initial burst of ≤2 flits, one flit per 4 cycles.
  - Required: `in_ready` stays low on starved cycles.
- **Backpressure.** `out_ready` toggles 1,0,0,1 during a 3-flit packet.
  - Required: data holds stable while `out_valid`=1 and `out_ready`=0.
  - Required: tokens are consumed only on handshakes.
- **Simultaneous refill and consume at saturation.** size=2, tokens=2, inc=1.
  - Required: a refill and a handshake in the same cycle leave tokens=1.
- **Reset mid-packet.** Assert reset during flit 2 of 5.
  - Required: next cycle `busy`=0, `out_valid`=0, tokens=0.
  - Required: after release, requester 0 is granted first.

Source files
------------

// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: packet-level round-robin merge of N_IN flit streams onto net_out,
// with token-bucket pacing of egress flits.
module net_tx_arbiter #(
    parameter int N_IN = 2,
    parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_IN-1:0]      in_valid,
    output logic [N_IN-1:0]      in_ready,
    input  logic [64*N_IN-1:0]   in_data,
    input  logic [8*N_IN-1:0]    in_keep,
    input  logic [N_IN-1:0]      in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic [7:0]           out_keep,
    output logic                 out_last,
    input  logic [7:0]           rlimit_inc,
    input  logic [7:0]           rlimit_period,
    input  logic [7:0]           rlimit_size,
    output logic [IDX_W-1:0]     grant,
    output logic                 busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] grant_n, last_grant, last_grant_n, pick, cand;
    logic found, refill, has_tokens, hs;
    logic [7:0] period_cnt;
    logic [8:0] tokens, tokens_n;
    logic [9:0] filled, capped;
    logic [63:0] data_a [N_IN];
    logic [7:0] keep_a [N_IN];
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            data_a[i] = in_data[64*i +: 64];
            keep_a[i] = in_keep[8*i +: 8];
        end
    end
    assign busy       = state == BUSY;
    assign has_tokens = tokens != 9'd0;
    assign out_valid  = busy && in_valid[grant] && has_tokens;
    assign out_data   = busy ? data_a[grant] : 64'd0;
    assign out_keep   = busy ? keep_a[grant] : 8'd0;
    assign out_last   = busy && in_last[grant];
    assign in_ready   = (busy && out_ready && has_tokens) ? N_IN'(1) << grant : '0;
    assign hs         = out_valid && out_ready;
    // Saturate the refilled bucket first, then consume, so refill+handshake at the cap nets -1.
    assign refill   = period_cnt == rlimit_period;
    assign filled   = {1'b0, tokens} + (refill ? {2'b0, rlimit_inc} : 10'd0);
    assign capped   = (filled > {2'b0, rlimit_size}) ? {2'b0, rlimit_size} : filled;
    assign tokens_n = 9'(capped - {9'd0, hs});
    always_comb begin
        found = 1'b0;
        pick  = last_grant;
        cand  = last_grant;
        for (int k = 1; k <= N_IN; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_IN);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        if (state == IDLE) begin
            state_n = found ? BUSY : IDLE;
            grant_n = found ? pick : grant;
        end else if (hs && out_last) begin
            state_n      = IDLE;
            last_grant_n = grant;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_IN - 1);
            period_cnt <= 8'd0;
            tokens     <= 9'd0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            period_cnt <= refill ? 8'd0 : period_cnt + 8'd1;
            tokens     <= tokens_n;
        end
    end
endmodule

// File: tb/tb_net_tx_arbiter.sv
// tb_net_tx_arbiter: randomized traffic against a token-bucket / round-robin reference,
// with a scoreboard of per-requester expected flits popped on each egress handshake.
module tb_net_tx_arbiter;
    localparam int N = 3;
    localparam int IW = 2;
    typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last;} flit_t;

    logic clock = 0, reset = 1;
    logic [N-1:0] in_valid = '0, in_ready, in_last = '0;
    logic [64*N-1:0] in_data = '0;
    logic [8*N-1:0] in_keep = '0;
    logic out_valid, out_ready = 0, out_last, busy;
    logic [63:0] out_data;
    logic [7:0] out_keep;
    logic [7:0] rl_inc = 1, rl_period = 0, rl_size = 8;
    logic [IW-1:0] grant;

    flit_t src_q [N][$];
    flit_t exp_q [N][$];
    int tests = 0, fails = 0;
    int valid_pct = 100, ready_pct = 100;
    int cyc_abs = 0;
    int hs_cyc[$];
    int grant_seq[$];
    logic rst_s = 1;
    logic [N-1:0] acc = '0;

    net_tx_arbiter #(.N_IN(N), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .rlimit_inc(rl_inc), .rlimit_period(rl_period), .rlimit_size(rl_size),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) rst_s <= reset;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int lg, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(lg + k) % N]) return (lg + k) % N;
        return lg;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size() + exp_q[i].size();
        return s;
    endfunction

    // Reference: bucket refills every (period+1) cycles from release, capped at size, then consumed.
    initial begin
        int tok_m, cyc_m, lg_m, grant_m, t;
        bit busy_m, fresh, ov, hs, refill;
        logic [N-1:0] er;
        flit_t f;
        tok_m = 0; cyc_m = 0; lg_m = N - 1; grant_m = 0; busy_m = 0; fresh = 0;
        forever begin
            @(negedge clock);
            cyc_abs++;
            if (rst_s) begin
                tok_m = 0; cyc_m = 0; lg_m = N - 1; grant_m = 0; busy_m = 0; fresh = 0;
                for (int i = 0; i < N; i++) exp_q[i].delete();
            end
            check("busy", 80'(busy), 80'(busy_m));
            hs = 0;
            if (busy_m) begin
                check("grant", 80'(grant), 80'(grant_m));
                if (fresh) grant_seq.push_back(int'(grant));
                fresh = 0;
                ov = in_valid[grant_m] && tok_m != 0;
                hs = ov && out_ready;
                er = '0;
                if (out_ready && tok_m != 0) er[grant_m] = 1'b1;
                check("out_valid", 80'(out_valid), 80'(ov));
                check("in_ready", 80'(in_ready), 80'(er));
                if (hs) begin
                    hs_cyc.push_back(cyc_abs);
                    if (exp_q[grant_m].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL flit: got unexpected flit from %0d expected none", grant_m);
                    end else begin
                        f = exp_q[grant_m].pop_front();
                        check("flit", 80'({out_data, out_keep, out_last}), 80'(f));
                    end
                end
            end else begin
                check("idle_out", 80'({out_valid, in_ready, out_data, out_keep, out_last}), 80'(0));
            end
            refill = (cyc_m % (rl_period + 1)) == rl_period;
            t = tok_m + (refill ? int'(rl_inc) : 0);
            if (t > int'(rl_size)) t = rl_size;
            tok_m = t - int'(hs);
            cyc_m++;
            if (busy_m) begin
                if (hs && in_last[grant_m]) begin busy_m = 0; lg_m = grant_m; end
            end else if (in_valid != '0) begin
                busy_m = 1; grant_m = rr_pick(lg_m, in_valid); fresh = 1;
            end
            acc = in_valid & in_ready;
        end
    end

    // Requesters: once a flit is presented it is held until accepted.
    initial forever begin
        @(posedge clock); #2;
        if (reset) begin
            for (int i = 0; i < N; i++) src_q[i].delete();
            in_valid = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] && in_valid[i]) begin
                    void'(src_q[i].pop_front());
                    in_valid[i] = 1'b0;
                end
                if (!in_valid[i] && src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                    in_data[64*i +: 64] = src_q[i][0].data;
                    in_keep[8*i +: 8]   = src_q[i][0].keep;
                    in_last[i]          = src_q[i][0].last;
                    in_valid[i]         = 1'b1;
                end
            end
        end
        out_ready = $urandom_range(99) < ready_pct;
    end

    task automatic push_pkt(input int i, input int len);
        flit_t f;
        for (int k = 0; k < len; k++) begin
            f.data = {$urandom, $urandom};
            f.last = k == len - 1;
            f.keep = f.last ? 8'($urandom_range(1, 255)) : 8'hff;
            src_q[i].push_back(f);
            exp_q[i].push_back(f);
        end
    endtask

    task automatic do_reset(input logic [7:0] inc, input logic [7:0] per, input logic [7:0] size);
        @(posedge clock); #1;
        reset = 1; rl_inc = inc; rl_period = per; rl_size = size;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock); #1;
        hs_cyc.delete();
        grant_seq.delete();
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int c = 0; c < budget && !(pending() == 0 && !busy); c++) @(posedge clock);
        check({"drain_", name}, 80'(pending()), 80'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // full rate, single requester
        valid_pct = 100; ready_pct = 100;
        do_reset(1, 0, 8);
        push_pkt(0, 4);
        wait_drain(50, "full_rate");
        check("full_rate_count", 80'(hs_cyc.size()), 80'(4));
        if (hs_cyc.size() == 4) check("full_rate_span", 80'(hs_cyc[3] - hs_cyc[0]), 80'(3));

        // round-robin fairness with all requesters continuously valid
        do_reset(1, 0, 8);
        for (int p = 0; p < 4; p++) for (int i = 0; i < N; i++) push_pkt(i, 2);
        wait_drain(200, "rr");
        for (int k = 0; k < 6; k++)
            check("rr_seq", 80'(grant_seq.size() > k ? grant_seq[k] : -1), 80'(k % N));

        // rate limiting: one flit per 4 cycles
        do_reset(1, 3, 2);
        push_pkt(1, 10);
        wait_drain(100, "rate");
        check("rate_count", 80'(hs_cyc.size()), 80'(10));
        for (int k = 2; k < 10 && k < hs_cyc.size(); k++)
            check("rate_gap", 80'(hs_cyc[k] - hs_cyc[k-1]), 80'(4));

        // backpressure and sporadic valid
        valid_pct = 70; ready_pct = 50;
        do_reset(1, 0, 8);
        for (int p = 0; p < 30; p++) push_pkt($urandom_range(N - 1), $urandom_range(1, 5));
        wait_drain(2000, "backpressure");

        // bucket saturates, then refill and consume coincide at the cap
        valid_pct = 100; ready_pct = 0;
        do_reset(1, 1, 2);
        push_pkt(0, 6);
        repeat (10) @(posedge clock);
        #1 ready_pct = 100;
        wait_drain(100, "saturate");
        check("saturate_count", 80'(hs_cyc.size()), 80'(6));

        // reset during flit 2 of 5, then requester 0 wins first
        do_reset(1, 0, 8);
        push_pkt(2, 5);
        for (int c = 0; c < 50 && hs_cyc.size() < 1; c++) @(negedge clock);
        check("midpkt_first_flit", 80'(hs_cyc.size() >= 1), 80'(1));
        do_reset(1, 0, 8);
        for (int i = 0; i < N; i++) push_pkt(i, 2);
        wait_drain(100, "after_reset");
        check("after_reset_first_grant", 80'(grant_seq.size() > 0 ? grant_seq[0] : -1), 80'(0));

        // zero-size bucket blocks egress
        do_reset(1, 0, 0);
        push_pkt(0, 3);
        repeat (40) @(posedge clock);
        check("blocked", 80'(hs_cyc.size()), 80'(0));

        // random configurations with live inc/size changes
        for (int r = 0; r < 4; r++) begin
            valid_pct = 80; ready_pct = 70;
            do_reset(8'($urandom_range(1, 3)), 8'($urandom_range(0, 4)), 8'($urandom_range(1, 6)));
            for (int p = 0; p < 20; p++) push_pkt($urandom_range(N - 1), $urandom_range(1, 4));
            repeat (100) @(posedge clock);
            #1;
            rl_inc = 8'($urandom_range(1, 3));
            rl_size = 8'($urandom_range(1, 6));
            wait_drain(3000, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
